matd_reader: RTL and testbench

MATD_READER -- requirements
Module: matd_reader

---
 rtl/matd_pkg.sv | 36 +++
 rtl/matd_row_acc.sv | 54 +++++
 rtl/matd_reader.sv | 155 +++++++++++++++
 tb/tb_matd_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matd_pkg
// Description : Shared defaults, accumulator width and FSM state encoding
//               for the matrix-D streaming reader.
// Revision    : 1.0 - initial release
// ============================================================================
package matd_pkg;

  // Default geometry and bus widths of matrix D
  localparam int M_DEF    = 3;
  localparam int R_DEF    = 5;
  localparam int BASE_DEF = 1;
  localparam int AW_DEF   = 8;
  localparam int DW_DEF   = 32;

  // Row accumulator width: four guard bits cover up to 16 columns
  localparam int ACCW = DW_DEF + 4;

  // Reader FSM encoding (explicit width, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_CAPTURE = ST_CAPTURE,
    S_HOLD    = ST_HOLD,
    S_DONE    = ST_DONE
  } matd_state_e;

endpackage : matd_pkg
`default_nettype wire

// File: rtl/matd_row_acc.sv
`default_nettype none
// ============================================================================
// Module      : matd_row_acc
// Description : Unsigned per-row accumulator. Adds every handshaken element;
//               on the row-end handshake publishes the row total and pulses
//               row_sum_valid_o for one cycle, then restarts from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module matd_row_acc
  import matd_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = DW + 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   elem_i,
  input  logic            hs_i,
  input  logic            row_end_i,
  output logic [ACCW-1:0] row_sum_o,
  output logic            row_sum_valid_o
);

  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] sum_q;
  logic            pulse_q;
  logic [ACCW-1:0] acc_plus_w;

  assign acc_plus_w = acc_q + ACCW'(elem_i);

  // Accumulate on handshake; close the row and pulse on the last column
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      sum_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= hs_i & row_end_i;
      if (hs_i) begin
        if (row_end_i) begin
          sum_q <= acc_plus_w;
          acc_q <= '0;
        end else begin
          acc_q <= acc_plus_w;
        end
      end
    end
  end

  assign row_sum_o       = sum_q;
  assign row_sum_valid_o = pulse_q;

endmodule : matd_row_acc
`default_nettype wire

// File: rtl/matd_reader.sv
`default_nettype none
// ============================================================================
// Module      : matd_reader
// Description : Streams matrix D (M x R, row-major) out of a BRAM with a
//               registered read port, one element per valid/ready handshake.
//               Optional feature macro: MATD_ROWSUM_EN adds per-row sums.
// Revision    : 1.0 - initial release
// ============================================================================
module matd_reader
  import matd_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int R    = R_DEF,
  parameter int BASE = BASE_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrD_done,
  output logic [AW-1:0] addrbD,
  input  logic [DW-1:0] doutbD,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          done
`ifdef MATD_ROWSUM_EN
  ,
  output logic [DW+3:0] row_sum,
  output logic          row_sum_valid
`endif
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (R > 1) ? $clog2(R) : 1;

  matd_state_e   state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [JW-1:0] j_q, j_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;

  logic          hs_w;
  logic          row_end_w;
  logic          elem_last_w;

  // valid_q is only ever set in HOLD, so ready alone cannot advance anything
  assign hs_w        = valid_q & out_ready;
  assign row_end_w   = (j_q == JW'(R - 1));
  assign elem_last_w = (i_q == IW'(M - 1)) && row_end_w;

  // Next-state logic: issue, capture, hold until handshake, then advance
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        addr_d = AW'(BASE);
        if (wrD_done) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = doutbD;
        valid_d = 1'b1;
        last_d  = elem_last_w;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hs_w) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (elem_last_w) begin
            // Address stays on the final element; never runs past the matrix
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
            addr_d  = addr_q + AW'(1);
            if (row_end_w) begin
              j_d = '0;
              i_d = i_q + IW'(1);
            end else begin
              j_d = j_q + JW'(1);
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset to the idle/base condition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= AW'(BASE);
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign addrbD    = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;

`ifdef MATD_ROWSUM_EN
  matd_row_acc #(
    .DW   (DW),
    .ACCW (DW + 4)
  ) u_row_acc (
    .clk             (clk),
    .reset           (reset),
    .elem_i          (data_q),
    .hs_i            (hs_w),
    .row_end_i       (row_end_w),
    .row_sum_o       (row_sum),
    .row_sum_valid_o (row_sum_valid)
  );
`endif

endmodule : matd_reader
`default_nettype wire

// File: tb/tb_matd_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matd_reader
// Description : Directed self-checking bench for matd_reader with a small
//               registered-read BRAM model preloaded with 15,25,...,155.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matd_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wrD_done = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  addrbD;
  logic [31:0] doutbD;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        done;
`ifdef MATD_ROWSUM_EN
  logic [35:0] row_sum;
  logic        row_sum_valid;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int addr_bad = 0;
  logic [35:0] rs_q[$];
  logic [31:0] mem [0:255];

  matd_reader #(.M(3), .R(5), .BASE(1), .AW(8), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .wrD_done  (wrD_done),
    .addrbD    (addrbD),
    .doutbD    (doutbD),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
`ifdef MATD_ROWSUM_EN
    .row_sum       (row_sum),
    .row_sum_valid (row_sum_valid),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM model
  always @(posedge clk) doutbD <= mem[addrbD];

  // Address range monitor
  always @(posedge clk) if (!reset && (addrbD < 8'd1 || addrbD > 8'd15)) addr_bad++;

`ifdef MATD_ROWSUM_EN
  always @(negedge clk) if (row_sum_valid) rs_q.push_back(row_sum);
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wrD_done = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rs_q.delete();
  endtask

  task automatic wait_valid(output bit ok);
    int w = 0;
    while (!out_valid && w < 20) begin @(negedge clk); w++; end
    ok = out_valid;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL wait_valid: out_valid=%0b after %0d cycles, required 1", out_valid, w); end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0 || done !== 1'b0 || addrbD !== 8'd1) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b data=%0d last=%0b done=%0b addr=%0d, required 0 0 0 0 1",
               out_valid, out_data, out_last, done, addrbD);
    end
`ifdef MATD_ROWSUM_EN
    n_checks++;
    if (row_sum !== 36'd0 || row_sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rowsum: sum=%0d v=%0b, required 0 0", row_sum, row_sum_valid);
    end
`endif
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_idle_wait();
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || addrbD !== 8'd1 || done !== 1'b0) begin
        n_fail++; $display("FAIL idle_wait c=%0d: valid=%0b addr=%0d done=%0b, required 0 1 0", c, out_valid, addrbD, done);
      end
    end
  endtask

  task automatic test_stream();
    int w;
    do_reset();
    out_ready = 1'b1; wrD_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_c1: valid=%0b required 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || addrbD !== 8'd1) begin n_fail++; $display("FAIL latency_c2: valid=%0b addr=%0d required 0 1", out_valid, addrbD); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_c3: valid=%0b required 1", out_valid); end
    for (int k = 0; k < 15; k++) begin
      w = 0;
      while (!out_valid && w < 20) begin @(negedge clk); w++; end
      n_checks++;
      if (w !== ((k == 0) ? 0 : 2)) begin n_fail++; $display("FAIL throughput k=%0d: gap=%0d required %0d", k, w, (k == 0) ? 0 : 2); end
      n_checks++;
      if (out_data !== 32'(15 + 10*k) || out_last !== (k == 14)) begin
        n_fail++; $display("FAIL stream k=%0d: data=%0d last=%0b required %0d %0b", k, out_data, out_last, 15 + 10*k, k == 14);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || addrbD !== 8'd15) begin
      n_fail++; $display("FAIL done_after_last: done=%0b valid=%0b addr=%0d required 1 0 15", done, out_valid, addrbD);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || addrbD !== 8'd15) begin
      n_fail++; $display("FAIL done_sticky: done=%0b valid=%0b addr=%0d required 1 0 15", done, out_valid, addrbD);
    end
`ifdef MATD_ROWSUM_EN
    n_checks++;
    if (rs_q.size() != 3) begin
      n_fail++; $display("FAIL rowsum_count: %0d pulses, required 3", rs_q.size());
    end else if (rs_q[0] !== 36'd175 || rs_q[1] !== 36'd425 || rs_q[2] !== 36'd675) begin
      n_fail++; $display("FAIL rowsum_values: %0d %0d %0d, required 175 425 675", rs_q[0], rs_q[1], rs_q[2]);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    wrD_done = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid && out_data == 32'd45) begin out_ready = 1'b0; break; end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_data !== 32'd45 || out_valid !== 1'b1 || addrbD !== 8'd4) begin
        n_fail++; $display("FAIL backpressure c=%0d: data=%0d valid=%0b addr=%0d required 45 1 4", c, out_data, out_valid, addrbD);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    wait_valid(ok);
    n_checks++;
    if (out_data !== 32'd55 || addrbD !== 8'd5) begin
      n_fail++; $display("FAIL after_backpressure: data=%0d addr=%0d required 55 5", out_data, addrbD);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    wrD_done = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (out_valid && out_data == 32'd85) begin out_ready = 1'b0; break; end
    end
    @(negedge clk);
    n_checks++;
    if (out_data !== 32'd85 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL hold_85: data=%0d valid=%0b required 85 1", out_data, out_valid);
    end
    #2 reset = 1'b1; #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || addrbD !== 8'd1 || done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: valid=%0b data=%0d addr=%0d done=%0b required 0 0 1 0", out_valid, out_data, addrbD, done);
    end
    rs_q.delete();
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    wait_valid(ok);
    n_checks++;
    if (out_data !== 32'd15) begin n_fail++; $display("FAIL restart_first: data=%0d required 15", out_data); end
    for (int c = 0; c < 100 && !done; c++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: done=%0b required 1", done); end
`ifdef MATD_ROWSUM_EN
    n_checks++;
    if (rs_q.size() < 1 || rs_q[0] !== 36'd175) begin
      n_fail++; $display("FAIL restart_rowsum: first=%0d count=%0d required 175", (rs_q.size() > 0) ? rs_q[0] : 36'd0, rs_q.size());
    end
`endif
  endtask

  task automatic test_random_ready();
    int n = 0;
    do_reset();
    addr_bad = 0;
    wrD_done = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (done) break;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_data !== 32'(15 + 10*n)) begin
          n_fail++; $display("FAIL random_order n=%0d: data=%0d required %0d", n, out_data, 15 + 10*n);
        end
        n++;
      end
    end
    n_checks++;
    if (n != 15 || done !== 1'b1) begin n_fail++; $display("FAIL random_count: handshakes=%0d done=%0b required 15 1", n, done); end
    n_checks++;
    if (addr_bad != 0) begin n_fail++; $display("FAIL random_addr_range: %0d out-of-range cycles, required 0", addr_bad); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 32'hDEAD_0000 + 32'(a);
    for (int a = 1; a <= 15; a++) mem[a] = 32'(15 + 10*(a - 1));
    test_reset();
    test_idle_wait();
    test_stream();
    test_backpressure();
    test_mid_reset();
    test_random_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_matd_reader
`default_nettype wire
